uart_fifo_core: RTL and testbench

Parametrised UART with independent TX and RX FIFOs, runtime-selectable parity and stop bits, and a fractional baud generator. Successor to the single-buffer UART wrapper used on the SmartFusion2 fabric: the host side sees a strobe-based register-style interface (CSN/WEN/OEN, active-low), and the line side sees TX/RX pins. It adds configurable data width, FIFO buffering, occupancy counts, a false-start filter and explicit error clearing.

---
 rtl/uart_fifo_core.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core
// UART with separate TX and RX FIFOs, a fractional 16x baud generator,
// runtime parity/stop-bit selection and sticky error flags.
//
// Ports
//   CLK, RESET            system clock, asynchronous active-high reset
//   BAUD_VAL, BAUD_FRAC   tick period = BAUD_VAL+1 clocks plus BAUD_FRAC/8 on average
//   PARITY_EN, ODD_N_EVEN parity enable and sense
//   TWO_STOP              TX sends two stop bits when set
//   CSN, WEN, DATA_IN     active-low host write into the TX FIFO
//   CSN, OEN, DATA_OUT    active-low host pop of the RX FIFO (first-word fall-through)
//   CLR_ERR               pulse that clears the sticky error flags
//   RX, TX                serial line input and output
//   TXRDY, RXRDY, TX_BUSY FIFO / transmitter status
//   TX_COUNT, RX_COUNT    FIFO occupancy
//   OVERFLOW, PARITY_ERR, FRAMING_ERR  sticky error flags
module uart_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [12:0]                 BAUD_VAL,
    input  logic [2:0]                  BAUD_FRAC,
    input  logic                        PARITY_EN,
    input  logic                        ODD_N_EVEN,
    input  logic                        TWO_STOP,
    input  logic                        CSN,
    input  logic                        WEN,
    input  logic [DATA_WIDTH-1:0]       DATA_IN,
    input  logic                        OEN,
    input  logic                        CLR_ERR,
    input  logic                        RX,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic                        TX,
    output logic                        TXRDY,
    output logic                        RXRDY,
    output logic                        TX_BUSY,
    output logic [$clog2(TX_DEPTH):0]   TX_COUNT,
    output logic [$clog2(RX_DEPTH):0]   RX_COUNT,
    output logic                        OVERFLOW,
    output logic                        PARITY_ERR,
    output logic                        FRAMING_ERR
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int BW    = $clog2(DATA_WIDTH);

    localparam logic [TX_AW:0]  TX_FULL  = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0]  RX_FULL  = (RX_AW+1)'(RX_DEPTH);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP1  = 3'd4;
    localparam logic [2:0] TX_STOP2  = 3'd5;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    // ---------------------------------------------------------------
    // Baud generator
    // ---------------------------------------------------------------
    logic [12:0] baud_cnt;
    logic [2:0]  baud_phase;
    logic [2:0]  phase_next;
    logic        baud_extra;
    logic        baud_tick;

    assign phase_next = baud_phase + 3'd1;
    assign baud_tick  = (baud_cnt == 13'd0) && !baud_extra;

    // The counter runs BAUD_VAL..0; when the interval's phase is below
    // BAUD_FRAC, one extra clock is spent at zero before the tick fires,
    // so eight consecutive intervals add exactly BAUD_FRAC clocks.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baud_cnt   <= 13'd0;
            baud_phase <= 3'd0;
            baud_extra <= 1'b0;
        end else if (baud_tick) begin
            baud_cnt   <= BAUD_VAL;
            baud_phase <= phase_next;
            baud_extra <= (phase_next < BAUD_FRAC);
        end else if (baud_cnt == 13'd0) begin
            baud_extra <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt - 13'd1;
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]      tx_wr_ptr;
    logic [TX_AW-1:0]      tx_rd_ptr;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_push;
    logic                  tx_pop;
    logic [2:0]            tx_state;

    assign TXRDY   = (TX_COUNT != TX_FULL);
    assign tx_push = !CSN && !WEN && TXRDY;
    assign tx_pop  = (tx_state == TX_IDLE) && baud_tick && (TX_COUNT != '0);
    assign tx_head = tx_mem[tx_rd_ptr];
    assign TX_BUSY = (tx_state != TX_IDLE) || (TX_COUNT != '0);

    // Storage array carries no reset; only pointers and count do.
    always_ff @(posedge CLK) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= DATA_IN;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            TX_COUNT  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   TX_COUNT <= TX_COUNT + (TX_AW+1)'(1);
                2'b01:   TX_COUNT <= TX_COUNT - (TX_AW+1)'(1);
                default: TX_COUNT <= TX_COUNT;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // TX state machine
    // ---------------------------------------------------------------
    logic [3:0]            tx_tick_cnt;
    logic [BW-1:0]         tx_bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par_bit;
    logic                  tx_par_en_r;
    logic                  tx_two_stop_r;
    logic                  tx_line;

    assign TX = tx_line;

    // The line register is updated together with each state change so
    // TX always reflects the bit of the current state; the frame's
    // configuration is captured when the head word is popped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_state      <= TX_IDLE;
            tx_tick_cnt   <= 4'd0;
            tx_bit_cnt    <= '0;
            tx_shift      <= '0;
            tx_par_bit    <= 1'b0;
            tx_par_en_r   <= 1'b0;
            tx_two_stop_r <= 1'b0;
            tx_line       <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            tx_line <= 1'b1;
            if (tx_pop) begin
                tx_shift      <= tx_head;
                tx_par_bit    <= (^tx_head) ^ ODD_N_EVEN;
                tx_par_en_r   <= PARITY_EN;
                tx_two_stop_r <= TWO_STOP;
                tx_tick_cnt   <= 4'd0;
                tx_state      <= TX_START;
                tx_line       <= 1'b0;
            end
        end else if (baud_tick) begin
            if (tx_tick_cnt != 4'd15) begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end else begin
                tx_tick_cnt <= 4'd0;
                case (tx_state)
                    TX_START: begin
                        tx_state   <= TX_DATA;
                        tx_bit_cnt <= '0;
                        tx_line    <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_cnt == LAST_BIT) begin
                            tx_state <= tx_par_en_r ? TX_PARITY : TX_STOP1;
                            tx_line  <= tx_par_en_r ? tx_par_bit : 1'b1;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + BW'(1);
                            tx_shift   <= tx_shift >> 1;
                            tx_line    <= tx_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP1;
                        tx_line  <= 1'b1;
                    end
                    TX_STOP1: begin
                        tx_state <= tx_two_stop_r ? TX_STOP2 : TX_IDLE;
                        tx_line  <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        tx_line  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // RX synchroniser and state machine
    // ---------------------------------------------------------------
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    logic                  rx_fall;
    logic [2:0]            rx_state;
    logic [3:0]            rx_tick_cnt;
    logic [BW-1:0]         rx_bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par_en_r;
    logic                  rx_odd_r;
    logic                  rx_par_bad;
    logic                  rx_sample;
    logic                  rx_push_req;

    assign rx_fall     = rx_prev && !rx_sync;
    assign rx_sample   = baud_tick && (rx_state != RX_IDLE) &&
                         ((rx_state == RX_START) ? (rx_tick_cnt == 4'd7)
                                                 : (rx_tick_cnt == 4'd15));
    assign rx_push_req = rx_sample && (rx_state == RX_STOP);

    // Two flops bring RX into the clock domain; a third keeps the previous
    // value so a falling edge can be seen. Reset to the idle-high level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // The start bit is checked halfway (8 ticks) to reject glitches; all
    // later samples are 16 ticks apart, landing at each bit centre.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state    <= RX_IDLE;
            rx_tick_cnt <= 4'd0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_par_en_r <= 1'b0;
            rx_odd_r    <= 1'b0;
            rx_par_bad  <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_fall) begin
                rx_state    <= RX_START;
                rx_tick_cnt <= 4'd0;
                rx_par_en_r <= PARITY_EN;
                rx_odd_r    <= ODD_N_EVEN;
                rx_par_bad  <= 1'b0;
            end
        end else begin
            if (baud_tick) begin
                rx_tick_cnt <= rx_sample ? 4'd0 : rx_tick_cnt + 4'd1;
            end
            if (rx_sample) begin
                case (rx_state)
                    RX_START: begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state   <= RX_DATA;
                            rx_bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_bit_cnt == LAST_BIT) begin
                            rx_state <= rx_par_en_r ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + BW'(1);
                        end
                    end
                    RX_PARITY: begin
                        rx_par_bad <= (rx_sync != ((^rx_shift) ^ rx_odd_r));
                        rx_state   <= RX_STOP;
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // RX FIFO
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]      rx_wr_ptr;
    logic [RX_AW-1:0]      rx_rd_ptr;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;

    assign rx_full  = (RX_COUNT == RX_FULL);
    assign RXRDY    = (RX_COUNT != '0);
    assign rx_push  = rx_push_req && !rx_full;
    assign rx_pop   = !CSN && !OEN && RXRDY;
    assign DATA_OUT = RXRDY ? rx_mem[rx_rd_ptr] : '0;

    // Storage array carries no reset; DATA_OUT is masked while empty.
    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_shift;
        end
    end

    // Received words are stored even when flagged with an error.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            RX_COUNT  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   RX_COUNT <= RX_COUNT + (RX_AW+1)'(1);
                2'b01:   RX_COUNT <= RX_COUNT - (RX_AW+1)'(1);
                default: RX_COUNT <= RX_COUNT;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Sticky error flags: a set on the same clock as CLR_ERR wins.
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVERFLOW    <= 1'b0;
            PARITY_ERR  <= 1'b0;
            FRAMING_ERR <= 1'b0;
        end else begin
            if (rx_push_req && rx_full)     OVERFLOW    <= 1'b1;
            else if (CLR_ERR)               OVERFLOW    <= 1'b0;
            if (rx_push_req && rx_par_bad)  PARITY_ERR  <= 1'b1;
            else if (CLR_ERR)               PARITY_ERR  <= 1'b0;
            if (rx_push_req && !rx_sync)    FRAMING_ERR <= 1'b1;
            else if (CLR_ERR)               FRAMING_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core
// Directed checks of uart_fifo_core with 4-entry FIFOs: reset state,
// loopback, TX framing, RX errors, overflow/full, false start,
// fractional baud timing and reset in the middle of a frame.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] baud_val = 13'd3;
    logic [2:0]  baud_frac = 3'd0;
    logic        parity_en = 1'b0;
    logic        odd_n_even = 1'b0;
    logic        two_stop = 1'b0;
    logic        csn = 1'b1;
    logic        wen = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        oen = 1'b1;
    logic        clr_err = 1'b0;
    logic        rx_drive = 1'b1;
    logic        loop_mode = 1'b0;
    logic        rx_line;
    logic [7:0]  data_out;
    logic        tx;
    logic        txrdy;
    logic        rxrdy;
    logic        tx_busy;
    logic [2:0]  tx_count;
    logic [2:0]  rx_count;
    logic        overflow;
    logic        parity_err;
    logic        framing_err;

    int assertions = 0;
    int failures   = 0;

    assign rx_line = loop_mode ? tx : rx_drive;

    // 10 ns system clock.
    always #5 clk = ~clk;

    uart_fifo_core #(
        .DATA_WIDTH(8),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .BAUD_VAL   (baud_val),
        .BAUD_FRAC  (baud_frac),
        .PARITY_EN  (parity_en),
        .ODD_N_EVEN (odd_n_even),
        .TWO_STOP   (two_stop),
        .CSN        (csn),
        .WEN        (wen),
        .DATA_IN    (data_in),
        .OEN        (oen),
        .CLR_ERR    (clr_err),
        .RX         (rx_line),
        .DATA_OUT   (data_out),
        .TX         (tx),
        .TXRDY      (txrdy),
        .RXRDY      (rxrdy),
        .TX_BUSY    (tx_busy),
        .TX_COUNT   (tx_count),
        .RX_COUNT   (rx_count),
        .OVERFLOW   (overflow),
        .PARITY_ERR (parity_err),
        .FRAMING_ERR(framing_err)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Applies the line configuration used by the next scenario.
    task automatic applyStimulus(input logic [12:0] bv, input logic [2:0] frac,
                                 input logic pen, input logic odd, input logic two);
        baud_val   = bv;
        baud_frac  = frac;
        parity_en  = pen;
        odd_n_even = odd;
        two_stop   = two;
    endtask

    task automatic applyReset();
        @(negedge clk);
        csn = 1'b1; wen = 1'b1; oen = 1'b1; clr_err = 1'b0;
        rx_drive = 1'b1; loop_mode = 1'b0; data_in = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic writeTx(input logic [7:0] d);
        @(negedge clk);
        csn = 1'b0; wen = 1'b0; data_in = d;
        @(negedge clk);
        csn = 1'b1; wen = 1'b1;
    endtask

    task automatic popRx();
        @(negedge clk);
        csn = 1'b0; oen = 1'b0;
        @(negedge clk);
        csn = 1'b1; oen = 1'b1;
    endtask

    // Drives one frame onto RX, followed by one idle bit time.
    task automatic sendFrame(input logic [7:0] data, input logic use_par,
                             input logic par_bit, input logic stop_bit, input int bit_clks);
        @(negedge clk);
        rx_drive = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drive = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        if (use_par) begin
            rx_drive = par_bit;
            repeat (bit_clks) @(negedge clk);
        end
        rx_drive = stop_bit;
        repeat (bit_clks) @(negedge clk);
        rx_drive = 1'b1;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic waitRxCount(input logic [2:0] target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_count == target) break;
        end
        checkOutput(tag, rx_count, target);
    endtask

    // Counts clocks (sampled 1 ns after each rising edge) until TX == level.
    task automatic waitTxLevel(input logic level, input int budget, output int clocks);
        clocks = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            clocks++;
            if (tx == level) break;
        end
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [11:0] frame_exp;
    logic [7:0]  words [5];
    int          n;

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;

        // Reset values.
        applyStimulus(13'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        applyReset();
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_txrdy", txrdy, 1);
        checkOutput("rst_rxrdy", rxrdy, 0);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_tx_count", tx_count, 0);
        checkOutput("rst_rx_count", rx_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_parity_err", parity_err, 0);
        checkOutput("rst_framing_err", framing_err, 0);

        // Loopback of two words.
        $display("[TB] loopback");
        loop_mode = 1'b1;
        writeTx(8'hA5);
        writeTx(8'h3C);
        waitRxCount(3'd2, 4000, "loop_rx_count");
        checkOutput("loop_word0", data_out, 8'hA5);
        popRx();
        checkOutput("loop_word1", data_out, 8'h3C);
        checkOutput("loop_count_after_pop", rx_count, 1);
        checkOutput("loop_overflow", overflow, 0);
        checkOutput("loop_parity_err", parity_err, 0);
        checkOutput("loop_framing_err", framing_err, 0);
        popRx();
        checkOutput("loop_rxrdy_empty", rxrdy, 0);

        // TX framing: 0x07, even parity, two stop bits, one tick per clock.
        $display("[TB] tx framing");
        applyStimulus(13'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        applyReset();
        frame_exp = 12'b1110_0000_1110;
        writeTx(8'h07);
        waitTxLevel(1'b0, 100, n);
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (k != 0 || j != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (j == 0 || j == 15) begin
                    checkOutput($sformatf("frame_bit%0d_clk%0d", k, j), tx, frame_exp[k]);
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("frame_idle_tx", tx, 1);
        checkOutput("frame_idle_busy", tx_busy, 0);

        // RX errors: 0x55 with wrong (odd) parity bit and a low stop bit.
        $display("[TB] rx errors");
        applyStimulus(13'd3, 3'd0, 1'b1, 1'b0, 1'b0);
        applyReset();
        sendFrame(8'h55, 1'b1, 1'b1, 1'b0, 64);
        waitRxCount(3'd1, 200, "err_rx_count");
        checkOutput("err_word", data_out, 8'h55);
        checkOutput("err_parity_set", parity_err, 1);
        checkOutput("err_framing_set", framing_err, 1);
        checkOutput("err_overflow_clear", overflow, 0);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("err_parity_cleared", parity_err, 0);
        checkOutput("err_framing_cleared", framing_err, 0);

        // RX overflow: five frames into a four-entry FIFO.
        $display("[TB] rx overflow");
        applyStimulus(13'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        applyReset();
        for (int i = 0; i < 5; i++) begin
            sendFrame(words[i], 1'b0, 1'b0, 1'b1, 64);
            if (i == 3) begin
                checkOutput("ovf_count_at_4", rx_count, 4);
                checkOutput("ovf_flag_at_4", overflow, 0);
            end
        end
        checkOutput("ovf_count_at_5", rx_count, 4);
        checkOutput("ovf_flag_at_5", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf_word%0d", i), data_out, words[i]);
            popRx();
        end
        checkOutput("ovf_fifth_absent", rx_count, 0);
        checkOutput("ovf_rxrdy_empty", rxrdy, 0);

        // TX full with the transmitter stalled, then drained via loopback.
        $display("[TB] tx full");
        applyStimulus(13'd8191, 3'd0, 1'b0, 1'b0, 1'b0);
        applyReset();
        for (int i = 0; i < 5; i++) begin
            writeTx(words[i]);
            if (i == 2) checkOutput("full_txrdy_at_3", txrdy, 1);
            if (i == 3) begin
                checkOutput("full_txrdy_at_4", txrdy, 0);
                checkOutput("full_count_at_4", tx_count, 4);
            end
        end
        checkOutput("full_count_at_5", tx_count, 4);
        checkOutput("full_tx_busy", tx_busy, 1);
        baud_val  = 13'd0;
        loop_mode = 1'b1;
        waitRxCount(3'd4, 12000, "full_drain_rx_count");
        checkOutput("full_tx_drained", tx_count, 0);
        repeat (400) @(negedge clk);
        checkOutput("full_no_fifth_count", rx_count, 4);
        checkOutput("full_no_fifth_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("full_word%0d", i), data_out, words[i]);
            popRx();
        end

        // False start: a 4-tick low glitch, then a good frame.
        $display("[TB] false start");
        applyStimulus(13'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        applyReset();
        @(negedge clk);
        rx_drive = 1'b0;
        repeat (16) @(negedge clk);
        rx_drive = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitch_rx_count", rx_count, 0);
        checkOutput("glitch_overflow", overflow, 0);
        checkOutput("glitch_parity_err", parity_err, 0);
        checkOutput("glitch_framing_err", framing_err, 0);
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b1, 64);
        checkOutput("glitch_then_frame_count", rx_count, 1);
        checkOutput("glitch_then_frame_word", data_out, 8'h5A);

        // Fractional baud: 16 ticks of 9+1+4/8 clocks = 168 clocks per bit.
        $display("[TB] fractional baud");
        applyStimulus(13'd9, 3'd4, 1'b0, 1'b0, 1'b0);
        applyReset();
        writeTx(8'h02);
        waitTxLevel(1'b0, 200, n);
        checkOutput("frac_start_seen", tx, 0);
        waitTxLevel(1'b1, 1000, n);
        checkOutput("frac_start_bit0_clocks", n, 336);
        waitTxLevel(1'b0, 1000, n);
        checkOutput("frac_bit1_clocks", n, 168);

        // Reset during the DATA state of a frame.
        $display("[TB] reset mid-frame");
        applyStimulus(13'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        applyReset();
        loop_mode = 1'b1;
        writeTx(8'hF0);
        writeTx(8'h0F);
        waitTxLevel(1'b0, 200, n);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("mid_tx_in_data", tx, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_tx", tx, 1);
        checkOutput("mid_rst_txrdy", txrdy, 1);
        checkOutput("mid_rst_rxrdy", rxrdy, 0);
        checkOutput("mid_rst_tx_busy", tx_busy, 0);
        checkOutput("mid_rst_tx_count", tx_count, 0);
        checkOutput("mid_rst_rx_count", rx_count, 0);
        checkOutput("mid_rst_data_out", data_out, 0);
        checkOutput("mid_rst_flags", {overflow, parity_err, framing_err}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        writeTx(8'h96);
        waitRxCount(3'd1, 2000, "mid_new_rx_count");
        checkOutput("mid_new_word", data_out, 8'h96);
        checkOutput("mid_new_flags", {overflow, parity_err, framing_err}, 0);
        repeat (800) @(negedge clk);
        checkOutput("mid_lost_word_absent", rx_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
